clock_monitor: RTL and testbench

Receive-side companion to the clock generator. Monitors a generated clock (`MON_CLK`) from the system clock domain. Measures its period in system-clock cycles, declares lock after a run of in-range periods, and flags loss of clock or out-of-range periods. Sits beside the clock generator so that system logic and benches can qualify the generated clock before using it.

---
 rtl/clock_monitor_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 43 ++++
 rtl/clock_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_clock_monitor.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// ---------------------------------------------------------------------------
// clock_monitor_pkg
// Shared definitions for the clock monitor: the monitor state enumeration and
// the default values of the monitor parameters.
// ---------------------------------------------------------------------------
package clock_monitor_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MIN_PERIOD  = 4;
  localparam int DEF_MAX_PERIOD  = 64;
  localparam int DEF_TIMEOUT     = 256;
  localparam int DEF_LOCK_COUNT  = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EDGE = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_LOST      = 3'd4
  } mon_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the CLOCK domain through a SYNC_STAGES
// flop chain and produces a registered one-cycle pulse on each rising edge of
// the synchronized level. Rise latency from the async input is SYNC_STAGES+1
// CLOCK cycles.
//
// Ports:
//   CLOCK      in   sampling clock
//   RESET_N    in   asynchronous active-low reset (chain and pulse clear to 0)
//   async_sig  in   asynchronous input level
//   rise       out  one-cycle pulse per detected rising edge
// ---------------------------------------------------------------------------
module sync_edge_detect
  import clock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES  // must be >= 2
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic async_sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_d;
  logic                   rise_reg;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_chain <= '0;
      sync_d     <= 1'b0;
      rise_reg   <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_sig};
      sync_d     <= sync_chain[SYNC_STAGES-1];
      rise_reg   <= sync_chain[SYNC_STAGES-1] & ~sync_d;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/clock_monitor.sv
// ---------------------------------------------------------------------------
// clock_monitor
// Watches a generated clock (MON_CLK) from the CLOCK domain. Measures the
// MON_CLK period in CLOCK cycles, declares lock after LOCK_COUNT consecutive
// in-range periods, flags loss of clock after TIMEOUT cycles without a rising
// edge, and keeps sticky too-slow / too-fast error flags.
//
// Parameter constraints: MIN_PERIOD >= 4, MAX_PERIOD < TIMEOUT < 2**CNT_W,
// SYNC_STAGES >= 2.
//
// Ports:
//   CLOCK         in   system clock (only clock of the block)
//   RESET_N       in   asynchronous active-low reset
//   ENABLE        in   monitor enable; low forces IDLE and clears all status
//   MON_CLK       in   clock under test, asynchronous to CLOCK
//   PERIOD        out  last measured period in CLOCK cycles
//   PERIOD_VALID  out  one-cycle pulse when PERIOD updates
//   LOCKED        out  monitored clock stable and in range
//   LOST          out  no rising edge for TIMEOUT cycles
//   ERR_SLOW      out  sticky: a period exceeded MAX_PERIOD
//   ERR_FAST      out  sticky: a period was below MIN_PERIOD
// ---------------------------------------------------------------------------
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD  = DEF_MAX_PERIOD,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             MON_CLK,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             LOCKED,
  output logic             LOST,
  output logic             ERR_SLOW,
  output logic             ERR_FAST
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  MIN_C       = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_C       = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_LAST_C = LOCK_W'(LOCK_COUNT - 1);

  logic mon_edge;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .async_sig(MON_CLK),
    .rise     (mon_edge)
  );

  mon_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  period_reg, period_next;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic              period_valid_reg, period_valid_next;
  logic              err_slow_reg, err_slow_next;
  logic              err_fast_reg, err_fast_next;
  logic              locked_reg, lost_reg;

  logic too_slow;
  logic too_fast;
  logic in_range;
  logic timeout_hit;

  // The value of cnt at the edge cycle is the measured period.
  assign too_slow    = (cnt_reg > MAX_C);
  assign too_fast    = (cnt_reg < MIN_C);
  assign in_range    = !too_slow && !too_fast;
  assign timeout_hit = (cnt_reg == TIMEOUT_C);

  always_comb begin
    state_next        = state_reg;
    lock_cnt_next     = lock_cnt_reg;
    period_next       = period_reg;
    period_valid_next = 1'b0;
    err_slow_next     = err_slow_reg;
    err_fast_next     = err_fast_reg;

    // Free-running period counter: restarts at 1 on every edge, saturates.
    if (mon_edge) begin
      cnt_next = CNT_W'(1);
    end else if (cnt_reg != '1) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else begin
      cnt_next = cnt_reg;
    end

    // In every state the edge test comes before the timeout test, so an edge
    // coinciding with cnt == TIMEOUT keeps the monitor out of LOST.
    case (state_reg)
      ST_IDLE: begin
        cnt_next   = '0;
        state_next = ST_WAIT_EDGE;
      end

      // The interval before the first edge is partial and never reported.
      ST_WAIT_EDGE: begin
        if (mon_edge) begin
          state_next = ST_MEASURE;
        end else if (timeout_hit) begin
          state_next = ST_LOST;
        end
      end

      ST_MEASURE: begin
        if (mon_edge) begin
          period_valid_next = 1'b1;
          period_next       = cnt_reg;
          if (in_range) begin
            lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
            if (lock_cnt_reg == LOCK_LAST_C) begin
              state_next = ST_LOCKED;
            end
          end else begin
            lock_cnt_next = '0;
            err_slow_next = err_slow_reg | too_slow;
            err_fast_next = err_fast_reg | too_fast;
          end
        end else if (timeout_hit) begin
          state_next    = ST_LOST;
          lock_cnt_next = '0;
        end
      end

      ST_LOCKED: begin
        if (mon_edge) begin
          period_valid_next = 1'b1;
          period_next       = cnt_reg;
          if (!in_range) begin
            state_next    = ST_MEASURE;
            lock_cnt_next = '0;
            err_slow_next = err_slow_reg | too_slow;
            err_fast_next = err_fast_reg | too_fast;
          end
        end else if (timeout_hit) begin
          state_next    = ST_LOST;
          lock_cnt_next = '0;
        end
      end

      // The recovering edge only restarts measurement; its interval spans
      // the outage and is not reported.
      ST_LOST: begin
        if (mon_edge) begin
          state_next    = ST_MEASURE;
          lock_cnt_next = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Disable overrides everything above.
    if (!ENABLE) begin
      state_next        = ST_IDLE;
      cnt_next          = '0;
      lock_cnt_next     = '0;
      period_next       = '0;
      period_valid_next = 1'b0;
      err_slow_next     = 1'b0;
      err_fast_next     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      lock_cnt_reg     <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      err_slow_reg     <= 1'b0;
      err_fast_reg     <= 1'b0;
      locked_reg       <= 1'b0;
      lost_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      lock_cnt_reg     <= lock_cnt_next;
      period_reg       <= period_next;
      period_valid_reg <= period_valid_next;
      err_slow_reg     <= err_slow_next;
      err_fast_reg     <= err_fast_next;
      // Status flags are registered from the next state so they change in
      // the same cycle as PERIOD_VALID.
      locked_reg       <= (state_next == ST_LOCKED);
      lost_reg         <= (state_next == ST_LOST);
    end
  end

  assign PERIOD       = period_reg;
  assign PERIOD_VALID = period_valid_reg;
  assign LOCKED       = locked_reg;
  assign LOST         = lost_reg;
  assign ERR_SLOW     = err_slow_reg;
  assign ERR_FAST     = err_fast_reg;

endmodule

// File: tb/tb_clock_monitor.sv
// ---------------------------------------------------------------------------
// tb_clock_monitor
// Drives MON_CLK as whole CLOCK-cycle high/low phases changed on the falling
// edge of CLOCK. A rise-level reference model predicts, from the gap between
// consecutive MON_CLK rises, which rises report a period and what PERIOD,
// LOCKED and the error flags must show at that report. A scoreboard process
// compares every PERIOD_VALID against the predictions.
// ---------------------------------------------------------------------------
module tb_clock_monitor;

  localparam int TIMEOUT = 256;
  localparam int MIN_P   = 4;
  localparam int MAX_P   = 64;
  localparam int LOCK_N  = 4;
  // Rise driven on a falling CLOCK edge -> 3 rising edges to the internal
  // edge pulse, one more to PERIOD_VALID, sampled 1 ns after: 36 ns.
  localparam longint REPORT_LAT_NS = 36;

  logic        CLOCK   = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE  = 1'b0;
  logic        MON_CLK = 1'b0;
  logic [15:0] PERIOD;
  logic        PERIOD_VALID;
  logic        LOCKED;
  logic        LOST;
  logic        ERR_SLOW;
  logic        ERR_FAST;

  int checks = 0;
  int passes = 0;

  // Reference model state (rise-level view of the monitor)
  int   gap_cnt = 0;     // CLOCK cycles since the previous MON_CLK rise
  int   m_mode  = 0;     // 0: first rise pending, 1: measuring, 2: locked
  int   m_run   = 0;     // consecutive good periods
  logic m_slow  = 1'b0;
  logic m_fast  = 1'b0;

  typedef struct {
    logic [15:0] period;
    logic        locked;
    logic        slow;
    logic        fast;
    time         t_rise;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  time  last_valid_time = 0;

  clock_monitor #(
    .CNT_W      (16),
    .MIN_PERIOD (MIN_P),
    .MAX_PERIOD (MAX_P),
    .TIMEOUT    (TIMEOUT),
    .LOCK_COUNT (LOCK_N),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .MON_CLK     (MON_CLK),
    .PERIOD      (PERIOD),
    .PERIOD_VALID(PERIOD_VALID),
    .LOCKED      (LOCKED),
    .LOST        (LOST),
    .ERR_SLOW    (ERR_SLOW),
    .ERR_FAST    (ERR_FAST)
  );

  always #5 CLOCK = ~CLOCK;

  // Scoreboard: every PERIOD_VALID must match the oldest prediction.
  initial begin
    forever begin
      @(posedge CLOCK);
      #1;
      if (PERIOD_VALID === 1'b1) begin
        last_valid_time = $time;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: PERIOD=%0d reported, expected no report", PERIOD);
        end else begin
          cur = exp_q.pop_front();
          if ({PERIOD, LOCKED, ERR_SLOW, ERR_FAST, LOST} !==
              {cur.period, cur.locked, cur.slow, cur.fast, 1'b0} ||
              ($time - cur.t_rise) != REPORT_LAT_NS) begin
            $display("FAIL period_report: got PERIOD=%0d LOCKED=%b SLOW=%b FAST=%b LOST=%b lat=%0d, expected PERIOD=%0d LOCKED=%b SLOW=%b FAST=%b LOST=0 lat=%0d",
                     PERIOD, LOCKED, ERR_SLOW, ERR_FAST, LOST, $time - cur.t_rise,
                     cur.period, cur.locked, cur.slow, cur.fast, REPORT_LAT_NS);
          end else begin
            passes++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLOCK);
    gap_cnt++;
  endtask

  task automatic model_clear();
    m_mode = 0;
    m_run  = 0;
    m_slow = 1'b0;
    m_fast = 1'b0;
  endtask

  // Called at each MON_CLK rise: decides whether this rise reports a period.
  task automatic model_rise();
    int   gap;
    exp_t e;
    gap     = gap_cnt;
    gap_cnt = 0;
    if (m_mode == 0) begin
      m_mode = 1;
      m_run  = 0;
    end else if (gap > TIMEOUT) begin
      // clock was declared lost during this gap; this rise only recovers
      m_mode = 1;
      m_run  = 0;
    end else begin
      if (gap >= MIN_P && gap <= MAX_P) begin
        m_run++;
        if (m_run >= LOCK_N) m_mode = 2;
      end else begin
        m_run  = 0;
        m_mode = 1;
        if (gap > MAX_P) m_slow = 1'b1;
        else             m_fast = 1'b1;
      end
      e.period = 16'(gap);
      e.locked = (m_mode == 2);
      e.slow   = m_slow;
      e.fast   = m_fast;
      e.t_rise = $time;
      exp_q.push_back(e);
    end
  endtask

  // One MON_CLK period: hi cycles high then lo cycles low.
  task automatic clk_period(input int hi, input int lo);
    tick();
    MON_CLK = 1'b1;
    model_rise();
    repeat (hi - 1) tick();
    tick();
    MON_CLK = 1'b0;
    repeat (lo - 1) tick();
  endtask

  task automatic enable_fresh();
    ENABLE = 1'b0;
    repeat (2) tick();
    model_clear();
    ENABLE = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++;
    if ({PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST} !== 21'd0)
      $display("FAIL reset_outputs: got %h, expected 0", {PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST});
    else passes++;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    checks++;
    if ({PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST} !== 21'd0)
      $display("FAIL idle_outputs: got %h, expected 0", {PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST});
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_steady();
    enable_fresh();
    repeat (4) clk_period(4, 4);
    checks++;
    if (LOCKED !== 1'b0) $display("FAIL steady_prelock: LOCKED=%b, expected 0", LOCKED);
    else passes++;
    // 5th rise: LOCKED must appear exactly 4 CLOCK cycles later
    tick();
    MON_CLK = 1'b1;
    model_rise();
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLOCK);
      #1;
      checks++;
      if (LOCKED !== (i == 4))
        $display("FAIL steady_lock_time: cycle %0d after 5th rise LOCKED=%b, expected %b", i, LOCKED, (i == 4));
      else passes++;
    end
    gap_cnt += 3;  // falling edges passed while waiting on rising edges
    tick();
    MON_CLK = 1'b0;
    repeat (3) tick();
    repeat (3) clk_period(4, 4);
    checks++;
    if ({LOCKED, ERR_SLOW, ERR_FAST} !== 3'b100)
      $display("FAIL steady_status: LOCKED/SLOW/FAST=%b, expected 100", {LOCKED, ERR_SLOW, ERR_FAST});
    else passes++;
    $display("test_steady done");
  endtask

  task automatic test_stopped();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (LOST === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    // LOST visible 256 cycles after the last PERIOD_VALID; sampled on the
    // falling edge, i.e. 2564 ns after the 1 ns-delayed valid sample.
    checks++;
    if (!seen || ($time - last_valid_time) != 2564 || LOCKED !== 1'b0)
      $display("FAIL lost_timing: seen=%b dt=%0d LOCKED=%b, expected seen=1 dt=2564 LOCKED=0", seen, $time - last_valid_time, LOCKED);
    else passes++;
    repeat (6) clk_period(4, 4);
    checks++;
    if ({LOST, LOCKED} !== 2'b01)
      $display("FAIL lost_recover: LOST/LOCKED=%b, expected 01", {LOST, LOCKED});
    else passes++;
    $display("test_stopped done");
  endtask

  task automatic test_too_slow();
    enable_fresh();
    repeat (2) clk_period(35, 35);
    checks++;
    if ({ERR_SLOW, ERR_FAST, LOCKED} !== 3'b100)
      $display("FAIL slow_flag: SLOW/FAST/LOCKED=%b, expected 100", {ERR_SLOW, ERR_FAST, LOCKED});
    else passes++;
    repeat (2) clk_period(35, 35);
    repeat (5) clk_period(4, 4);
    checks++;
    if ({ERR_SLOW, LOCKED} !== 2'b11)
      $display("FAIL slow_relock: SLOW/LOCKED=%b, expected 11", {ERR_SLOW, LOCKED});
    else passes++;
    $display("test_too_slow done");
  endtask

  task automatic test_too_fast();
    enable_fresh();
    repeat (8) clk_period(2, 1);
    repeat (4) tick();
    checks++;
    if ({ERR_FAST, ERR_SLOW, LOCKED} !== 3'b100)
      $display("FAIL fast_flag: FAST/SLOW/LOCKED=%b, expected 100", {ERR_FAST, ERR_SLOW, LOCKED});
    else passes++;
    $display("test_too_fast done");
  endtask

  task automatic test_disable();
    enable_fresh();
    repeat (6) clk_period(4, 4);
    checks++;
    if (LOCKED !== 1'b1) $display("FAIL disable_prelock: LOCKED=%b, expected 1", LOCKED);
    else passes++;
    tick();
    ENABLE = 1'b0;
    model_clear();
    @(posedge CLOCK);
    #1;
    checks++;
    if ({PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST} !== 21'd0)
      $display("FAIL disable_clear: got %h, expected 0", {PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST});
    else passes++;
    repeat (2) tick();
    ENABLE = 1'b1;
    repeat (4) tick();
    repeat (3) clk_period(4, 4);
    $display("test_disable done");
  endtask

  task automatic test_boundary();
    enable_fresh();
    clk_period(2, 2);      // first rise, discarded
    clk_period(32, 32);    // reports 4
    clk_period(33, 32);    // reports 64
    clk_period(2, 1);      // reports 65
    clk_period(128, 128);  // reports 3
    clk_period(128, 129);  // reports 256: edge beats timeout
    repeat (6) clk_period(4, 4);  // first rise ends a 257 gap: lost, no report
    checks++;
    if ({ERR_SLOW, ERR_FAST, LOCKED, LOST} !== 4'b1110)
      $display("FAIL boundary_status: SLOW/FAST/LOCKED/LOST=%b, expected 1110", {ERR_SLOW, ERR_FAST, LOCKED, LOST});
    else passes++;
    $display("test_boundary done");
  endtask

  task automatic test_random();
    int r, p, hi;
    enable_fresh();
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      p = int'($urandom_range(257, 300));
      else if (r == 1) p = 3;
      else             p = int'($urandom_range(4, 80));
      hi = (p == 3) ? 2 : int'($urandom_range(2, p - 2));
      clk_period(hi, p - hi);
    end
    repeat (4) tick();
    checks++;
    if ({ERR_SLOW, ERR_FAST, LOCKED} !== {m_slow, m_fast, (m_mode == 2)})
      $display("FAIL random_status: SLOW/FAST/LOCKED=%b, expected %b", {ERR_SLOW, ERR_FAST, LOCKED}, {m_slow, m_fast, (m_mode == 2)});
    else passes++;
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    enable_fresh();
    repeat (3) clk_period(4, 4);
    tick();
    @(posedge CLOCK);
    #1;
    checks++;
    if (PERIOD !== 16'd8) $display("FAIL reset_mid_pre: PERIOD=%0d, expected 8", PERIOD);
    else passes++;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST} !== 21'd0)
      $display("FAIL reset_mid_clear: got %h, expected 0", {PERIOD, PERIOD_VALID, LOCKED, LOST, ERR_SLOW, ERR_FAST});
    else passes++;
    #2;
    RESET_N = 1'b1;
    model_clear();
    repeat (4) tick();
    repeat (6) clk_period(4, 4);
    checks++;
    if (LOCKED !== 1'b1) $display("FAIL reset_mid_relock: LOCKED=%b, expected 1", LOCKED);
    else passes++;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_steady();
    test_stopped();
    test_too_slow();
    test_too_fast();
    test_disable();
    test_boundary();
    test_random();
    test_reset_mid();
    repeat (8) tick();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL pending_reports: %0d predicted reports never seen, expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
